// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single RAM port arbiter between fetch and load/store sides
module mem_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              owner_ls_q, owner_ls_d;
    logic              last_ls_q, last_ls_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              pick_ls;

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        last_ls_d  = last_ls_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        pick_ls    = 1'b0;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        ls_rvalid  = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_w_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    // On contention the side that did not own the previous access wins.
                    pick_ls    = ls_req && (!if_req || !last_ls_q);
                    owner_ls_d = pick_ls;
                    last_ls_d  = pick_ls;
                    we_d       = pick_ls && ls_we;
                    addr_d     = pick_ls ? ls_addr : if_addr;
                    wdata_d    = pick_ls ? ls_wdata : '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if_gnt    = !owner_ls_q;
                ls_gnt    = owner_ls_q;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                ram_w_en  = we_q;
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                ram_addr = addr_q;
                if (cnt_q == 3'd0) begin
                    if (owner_ls_q) begin
                        ls_rdata_d = ram_rdata;
                    end else begin
                        if_rdata_d = ram_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if_rvalid = !owner_ls_q;
                ls_rvalid = owner_ls_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_ls_q <= 1'b0;
            last_ls_q  <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= 3'd0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            last_ls_q  <= last_ls_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - random and directed bench for mem_port_arbiter at RD_LAT 2 and 1
module tb_mem_port_arbiter;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, if_req, ls_req, ls_we;
    logic [AW-1:0] if_addr, ls_addr;
    logic [DW-1:0] ls_wdata;

    logic [1:0]    if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_w_en, busy;
    logic [DW-1:0] if_rdata  [2];
    logic [DW-1:0] ls_rdata  [2];
    logic [AW-1:0] ram_addr  [2];
    logic [DW-1:0] ram_wdata [2];
    logic [DW-1:0] ram_rdata [2];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [DW-1:0] init_word(input int a);
        case (a)
            16:      return 32'hE3A01005;
            5:       return 32'h12345678;
            default: return (DW'(a) * 32'h0001_0193) ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut_lat2 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_w_en(ram_w_en[0]),
        .ram_rdata(ram_rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_w_en(ram_w_en[1]),
        .ram_rdata(ram_rdata[1]), .busy(busy[1])
    );

    // RAM environment: read data appears RD_LAT cycles after the address.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic          filled0 = 1'b0;
    logic          filled1 = 1'b0;
    logic [DW-1:0] pipe0 [2];
    logic [DW-1:0] pipe1;

    always @(posedge clk) begin
        if (!filled0) begin
            for (int i = 0; i < DEPTH; i++) mem0[i] <= init_word(i);
            filled0 <= 1'b1;
        end else if (ram_w_en[0] === 1'b1) begin
            mem0[ram_addr[0]] <= ram_wdata[0];
        end
        pipe0[0] <= mem0[ram_addr[0]];
        pipe0[1] <= pipe0[0];
    end
    assign ram_rdata[0] = pipe0[1];

    always @(posedge clk) begin
        if (!filled1) begin
            for (int i = 0; i < DEPTH; i++) mem1[i] <= init_word(i);
            filled1 <= 1'b1;
        end else if (ram_w_en[1] === 1'b1) begin
            mem1[ram_addr[1]] <= ram_wdata[1];
        end
        pipe1 <= mem1[ram_addr[1]];
    end
    assign ram_rdata[1] = pipe1;

    // Reference model: one transaction record per DUT, outputs derived from its timeline.
    logic [DW-1:0] ref_mem [2][DEPTH];
    bit            ref_filled = 1'b0;
    bit            started [2];
    bit            act     [2];
    int            t0      [2];
    bit            t_ls    [2];
    bit            t_we    [2];
    logic [AW-1:0] t_addr  [2];
    logic [DW-1:0] t_wdata [2];
    logic [DW-1:0] t_rd    [2];
    bit            last_ls [2];
    int            free_at [2];
    logic [DW-1:0] e_if_rd [2];
    logic [DW-1:0] e_ls_rd [2];
    int            cyc = 0;

    task automatic check_outputs(input int k);
        int lat;
        bit issue, bsy, rv, addr_win;
        lat      = (k == 0) ? 2 : 1;
        issue    = act[k] && (cyc == t0[k] + 1);
        bsy      = act[k] && (cyc >= t0[k] + 1) && (cyc <= t0[k] + (t_we[k] ? 1 : lat + 2));
        rv       = act[k] && !t_we[k] && (cyc == t0[k] + lat + 2);
        addr_win = bsy && (cyc <= t0[k] + 1 + (t_we[k] ? 0 : lat));
        if (rv) begin
            if (t_ls[k]) e_ls_rd[k] = t_rd[k];
            else         e_if_rd[k] = t_rd[k];
        end
        chk($sformatf("lat%0d if_gnt cyc %0d", lat, cyc), 64'(if_gnt[k]), 64'(issue && !t_ls[k]));
        chk($sformatf("lat%0d ls_gnt cyc %0d", lat, cyc), 64'(ls_gnt[k]), 64'(issue && t_ls[k]));
        chk($sformatf("lat%0d ram_w_en cyc %0d", lat, cyc), 64'(ram_w_en[k]), 64'(issue && t_we[k]));
        chk($sformatf("lat%0d busy cyc %0d", lat, cyc), 64'(busy[k]), 64'(bsy));
        chk($sformatf("lat%0d if_rvalid cyc %0d", lat, cyc), 64'(if_rvalid[k]), 64'(rv && !t_ls[k]));
        chk($sformatf("lat%0d ls_rvalid cyc %0d", lat, cyc), 64'(ls_rvalid[k]), 64'(rv && t_ls[k]));
        chk($sformatf("lat%0d if_rdata cyc %0d", lat, cyc), 64'(if_rdata[k]), 64'(e_if_rd[k]));
        chk($sformatf("lat%0d ls_rdata cyc %0d", lat, cyc), 64'(ls_rdata[k]), 64'(e_ls_rd[k]));
        if (!bsy) begin
            chk($sformatf("lat%0d ram_addr idle cyc %0d", lat, cyc), 64'(ram_addr[k]), 64'd0);
            chk($sformatf("lat%0d ram_wdata idle cyc %0d", lat, cyc), 64'(ram_wdata[k]), 64'd0);
        end else if (addr_win) begin
            chk($sformatf("lat%0d ram_addr cyc %0d", lat, cyc), 64'(ram_addr[k]), 64'(t_addr[k]));
        end
        if (issue && t_we[k])
            chk($sformatf("lat%0d ram_wdata cyc %0d", lat, cyc), 64'(ram_wdata[k]), 64'(t_wdata[k]));
    endtask

    task automatic predict(input int k);
        int lat;
        lat = (k == 0) ? 2 : 1;
        if (rst_n === 1'b0) begin
            started[k] = 1'b1;
            act[k]     = 1'b0;
            e_if_rd[k] = '0;
            e_ls_rd[k] = '0;
            last_ls[k] = 1'b1;
            free_at[k] = cyc + 1;
        end else if (started[k] && cyc >= free_at[k] && (if_req || ls_req)) begin
            if (if_req && ls_req) t_ls[k] = !last_ls[k];
            else                  t_ls[k] = ls_req;
            last_ls[k] = t_ls[k];
            act[k]     = 1'b1;
            t0[k]      = cyc;
            t_we[k]    = t_ls[k] && ls_we;
            t_addr[k]  = t_ls[k] ? ls_addr : if_addr;
            t_wdata[k] = t_ls[k] ? ls_wdata : '0;
            if (t_we[k]) ref_mem[k][t_addr[k]] = t_wdata[k];
            else         t_rd[k] = ref_mem[k][t_addr[k]];
            free_at[k] = cyc + (t_we[k] ? 2 : lat + 3);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!ref_filled) begin
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = init_word(i);
                ref_filled = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                if (started[k]) check_outputs(k);
                predict(k);
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n  = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    int order[$];
    bit found;
    bit g_if, g_ls;
    logic [DW-1:0] got;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;

        // IF read at RD_LAT 2
        do_reset();
        if_req = 1'b1; if_addr = 11'h010;
        @(negedge clk);
        chk("t1 reset busy", 64'(busy[0]), 64'd0);
        chk("t1 reset ram_addr", 64'(ram_addr[0]), 64'd0);
        chk("t1 reset if_rdata", 64'(if_rdata[0]), 64'd0);
        step(); if_req = 1'b0;
        @(negedge clk);
        chk("t1 if_gnt c1", 64'(if_gnt[0]), 64'd1);
        chk("t1 ram_addr c1", 64'(ram_addr[0]), 64'h010);
        step(); @(negedge clk);
        chk("t1 ram_addr c2", 64'(ram_addr[0]), 64'h010);
        step(); @(negedge clk);
        chk("t1 ram_addr c3", 64'(ram_addr[0]), 64'h010);
        chk("t1 busy c3", 64'(busy[0]), 64'd1);
        step(); @(negedge clk);
        chk("t1 if_rvalid c4", 64'(if_rvalid[0]), 64'd1);
        chk("t1 if_rdata c4", 64'(if_rdata[0]), 64'hE3A01005);
        step(); @(negedge clk);
        chk("t1 busy c5", 64'(busy[0]), 64'd0);

        // LS store then load back
        do_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 11'h7FF; ls_wdata = 32'hDEADBEEF;
        step(); ls_req = 1'b0;
        @(negedge clk);
        chk("t2 ls_gnt c1", 64'(ls_gnt[0]), 64'd1);
        chk("t2 ram_w_en c1", 64'(ram_w_en[0]), 64'd1);
        step(); @(negedge clk);
        chk("t2 busy c2", 64'(busy[0]), 64'd0);
        chk("t2 ls_rvalid c2", 64'(ls_rvalid[0]), 64'd0);
        step(); ls_req = 1'b1; ls_we = 1'b0;
        step(); ls_req = 1'b0;
        found = 1'b0; got = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ls_rvalid[0]) begin found = 1'b1; got = ls_rdata[0]; break; end
            step();
        end
        chk("t2 load rvalid seen", 64'(found), 64'd1);
        chk("t2 load data", 64'(got), 64'hDEADBEEF);

        // simultaneous requests after reset, each dropped after its grant
        do_reset();
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; if_addr = rnd_addr(); ls_addr = rnd_addr();
        order.delete();
        for (int i = 0; i < 40 && order.size() < 2; i++) begin
            @(negedge clk);
            g_if = if_gnt[0]; g_ls = ls_gnt[0];
            if (g_if) order.push_back(0);
            if (g_ls) order.push_back(1);
            step();
            if (g_if) if_req = 1'b0;
            if (g_ls) ls_req = 1'b0;
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("t3 grant count", 64'(order.size()), 64'd2);
        if (order.size() == 2) begin
            chk("t3 first grant", 64'(order[0]), 64'd0);
            chk("t3 second grant", 64'(order[1]), 64'd1);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy[0]) break;
            step();
        end
        step();
        if_req = 1'b1; ls_req = 1'b1;
        found = 1'b0; g_if = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_gnt[0] || ls_gnt[0]) begin found = 1'b1; g_if = if_gnt[0]; break; end
            step();
        end
        step(); if_req = 1'b0; ls_req = 1'b0;
        chk("t3 third grant seen", 64'(found), 64'd1);
        chk("t3 third grant is IF", 64'(g_if), 64'd1);

        // both requests held for six grants
        do_reset();
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; if_addr = rnd_addr(); ls_addr = rnd_addr();
        order.delete();
        for (int i = 0; i < 120 && order.size() < 6; i++) begin
            @(negedge clk);
            if (if_gnt[0]) order.push_back(0);
            if (ls_gnt[0]) order.push_back(1);
            step();
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("t4 grant count", 64'(order.size()), 64'd6);
        for (int i = 0; i < order.size() && i < 6; i++)
            chk($sformatf("t4 grant %0d", i), 64'(order[i]), 64'(i % 2));

        // reset during WAIT of an IF load with if_req held
        do_reset();
        if_req = 1'b1; if_addr = 11'h010;
        step(); @(negedge clk);
        chk("t5 if_gnt c1", 64'(if_gnt[0]), 64'd1);
        step(); rst_n = 1'b0;
        @(negedge clk);
        chk("t5 busy c2", 64'(busy[0]), 64'd1);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("t5 busy c3", 64'(busy[0]), 64'd0);
        chk("t5 ram_addr c3", 64'(ram_addr[0]), 64'd0);
        chk("t5 if_rvalid c3", 64'(if_rvalid[0]), 64'd0);
        step(); @(negedge clk);
        chk("t5 regrant c4", 64'(if_gnt[0]), 64'd1);
        chk("t5 if_rvalid c4", 64'(if_rvalid[0]), 64'd0);
        step(); if_req = 1'b0;

        // LS load with RD_LAT 1
        do_reset();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 11'h005;
        step(); ls_req = 1'b0;
        @(negedge clk);
        chk("t6 ls_gnt c1", 64'(ls_gnt[1]), 64'd1);
        step(); @(negedge clk);
        chk("t6 ls_rvalid c2", 64'(ls_rvalid[1]), 64'd0);
        step(); @(negedge clk);
        chk("t6 ls_rvalid c3", 64'(ls_rvalid[1]), 64'd1);
        chk("t6 ls_rdata c3", 64'(ls_rdata[1]), 64'h12345678);

        // random traffic with occasional resets
        do_reset();
        repeat (1500) begin
            if_req   = ($urandom_range(0, 2) == 0);
            ls_req   = ($urandom_range(0, 2) == 0);
            ls_we    = 1'($urandom_range(0, 1));
            if_addr  = rnd_addr();
            ls_addr  = rnd_addr();
            ls_wdata = $urandom;
            rst_n    = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0;
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
